// File: rtl/ones_accumulator.sv
// Frame-level population counter: counts ones in each word CHUNK_WIDTH bits per
// clock and accumulates across a frame, handing the total out on a valid/ready port.
module ones_accumulator #(
  parameter int unsigned INPUT_FEATURES = 8,
  parameter int unsigned CHUNK_WIDTH    = 4,
  parameter int unsigned MAX_WORDS      = 16,
  localparam int unsigned ACC_WIDTH     = $clog2(INPUT_FEATURES * MAX_WORDS + 1)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [INPUT_FEATURES-1:0] input_features_i,
  input  logic                      last_i,
  input  logic [ACC_WIDTH-1:0]      threshold_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [ACC_WIDTH-1:0]      ones_o,
  output logic                      above_o,
  output logic                      overflow_o
);

  localparam int unsigned STEPS  = INPUT_FEATURES / CHUNK_WIDTH;
  localparam int unsigned STEP_W = $clog2(STEPS + 1);
  localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [INPUT_FEATURES-1:0] shift_q, shift_d;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic                      closing_q, closing_d;
  logic                      flag_q, flag_d;
  logic [ACC_WIDTH-1:0]      thr_q, thr_d;
  logic                      valid_q, valid_d;
  logic [ACC_WIDTH-1:0]      ones_q, ones_d;
  logic                      above_q, above_d;
  logic                      ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]      acc_sum;
  logic                      closing_word;

  function automatic logic [ACC_WIDTH-1:0] popcount(input logic [CHUNK_WIDTH-1:0] chunk);
    logic [ACC_WIDTH-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < CHUNK_WIDTH; i++) begin
      cnt = cnt + ACC_WIDTH'(chunk[i]);
    end
    return cnt;
  endfunction

  // Acceptance is gated off while reset is asserted so no word slips in.
  assign ready_o    = (state_q == IDLE) && !reset_i;
  assign valid_o    = valid_q;
  assign ones_o     = ones_q;
  assign above_o    = above_q;
  assign overflow_o = ovf_q;

  // State and datapath registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      wcnt_q    <= '0;
      step_q    <= '0;
      closing_q <= 1'b0;
      flag_q    <= 1'b0;
      thr_q     <= '0;
      valid_q   <= 1'b0;
      ones_q    <= '0;
      above_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      wcnt_q    <= wcnt_d;
      step_q    <= step_d;
      closing_q <= closing_d;
      flag_q    <= flag_d;
      thr_q     <= thr_d;
      valid_q   <= valid_d;
      ones_q    <= ones_d;
      above_q   <= above_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    wcnt_d       = wcnt_q;
    step_d       = step_q;
    closing_d    = closing_q;
    flag_d       = flag_q;
    thr_d        = thr_q;
    valid_d      = valid_q;
    ones_d       = ones_q;
    above_d      = above_q;
    ovf_d        = ovf_q;
    acc_sum      = acc_q + popcount(shift_q[CHUNK_WIDTH-1:0]);
    closing_word = last_i || (wcnt_q == WCNT_W'(MAX_WORDS - 1));

    unique case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          shift_d   = input_features_i;
          wcnt_d    = wcnt_q + WCNT_W'(1);
          step_d    = '0;
          closing_d = closing_word;
          if (closing_word) begin
            thr_d  = threshold_i;
            flag_d = !last_i;
          end
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d   = acc_sum;
        shift_d = shift_q >> CHUNK_WIDTH;
        step_d  = step_q + STEP_W'(1);
        if (step_q == STEP_W'(STEPS - 1)) begin
          if (closing_q) begin
            state_d = DONE;
            ones_d  = acc_sum;
            above_d = (acc_sum >= thr_q);
            ovf_d   = flag_q;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
          acc_d   = '0;
          wcnt_d  = '0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ones_accumulator.sv
// Directed bench for ones_accumulator with INPUT_FEATURES=8, CHUNK_WIDTH=4, MAX_WORDS=4.
module tb_ones_accumulator;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] feat;
  logic       last;
  logic [5:0] thr;
  logic       valid_o;
  logic       ready_i;
  logic [5:0] ones;
  logic       above;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  ones_accumulator #(
    .INPUT_FEATURES(8),
    .CHUNK_WIDTH   (4),
    .MAX_WORDS     (4)
  ) dut (
    .clock_i         (clk),
    .reset_i         (reset_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .input_features_i(feat),
    .last_i          (last),
    .threshold_i     (thr),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .ones_o          (ones),
    .above_o         (above),
    .overflow_o      (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [7:0] w, input logic l, input logic [5:0] t);
    valid_i = 1'b1;
    feat    = w;
    last    = l;
    thr     = t;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    valid_i = 1'b1;
    feat    = 8'hFF;
    last    = 1'b1;
    thr     = 6'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ready_o !== 1'b0) begin $display("FAIL reset_ready cyc%0d: got %0d expected 0", i, ready_o); n_fail++; end
      n_checks++;
      if (valid_o !== 1'b0) begin $display("FAIL reset_valid cyc%0d: got %0d expected 0", i, valid_o); n_fail++; end
    end
    n_checks++;
    if (ones !== 6'd0 || above !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL reset_outputs: got ones=%0d above=%0d ovf=%0d expected 0/0/0", ones, above, ovf); n_fail++;
    end
    reset_i = 1'b0;
    valid_i = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin $display("FAIL reset_release_ready: got %0d expected 1", ready_o); n_fail++; end
    tick();
    n_checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      $display("FAIL reset_idle: got ready=%0d valid=%0d expected 1/0", ready_o, valid_o); n_fail++;
    end
  endtask

  task automatic test_single();
    drive_word(8'b1011_0110, 1'b1, 6'd5);
    n_checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
      $display("FAIL single_count1: got ready=%0d valid=%0d expected 0/0", ready_o, valid_o); n_fail++;
    end
    tick();
    n_checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
      $display("FAIL single_count2: got ready=%0d valid=%0d expected 0/0", ready_o, valid_o); n_fail++;
    end
    tick();
    n_checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      $display("FAIL single_done: got valid=%0d ready=%0d expected 1/0", valid_o, ready_o); n_fail++;
    end
    n_checks++;
    if (ones !== 6'd5 || above !== 1'b1 || ovf !== 1'b0) begin
      $display("FAIL single_result: got ones=%0d above=%0d ovf=%0d expected 5/1/0", ones, above, ovf); n_fail++;
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      $display("FAIL single_consume: got valid=%0d ready=%0d expected 0/1", valid_o, ready_o); n_fail++;
    end
  endtask

  task automatic test_frame();
    logic [7:0] words [3];
    words[0] = 8'hFF;
    words[1] = 8'h0F;
    words[2] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      drive_word(words[i], 1'b0, 6'd14);
      tick();
      tick();
      n_checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
        $display("FAIL frame_between%0d: got ready=%0d valid=%0d expected 1/0", i, ready_o, valid_o); n_fail++;
      end
    end
    drive_word(words[2], 1'b1, 6'd14);
    tick();
    tick();
    n_checks++;
    if (valid_o !== 1'b1) begin $display("FAIL frame_valid: got %0d expected 1", valid_o); n_fail++; end
    n_checks++;
    if (ones !== 6'd13 || above !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL frame_result: got ones=%0d above=%0d ovf=%0d expected 13/0/0", ones, above, ovf); n_fail++;
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive_word(8'hFF, 1'b0, 6'd32);
      tick();
      tick();
      if (i < 3) begin
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
          $display("FAIL ovf_between%0d: got ready=%0d valid=%0d expected 1/0", i, ready_o, valid_o); n_fail++;
        end
      end
    end
    n_checks++;
    if (valid_o !== 1'b1) begin $display("FAIL ovf_valid: got %0d expected 1", valid_o); n_fail++; end
    n_checks++;
    if (ones !== 6'd32 || above !== 1'b1 || ovf !== 1'b1) begin
      $display("FAIL ovf_result: got ones=%0d above=%0d ovf=%0d expected 32/1/1", ones, above, ovf); n_fail++;
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_word(8'h55, 1'b1, 6'd0);
    tick();
    tick();
    valid_i = 1'b1;
    feat    = 8'hFF;
    last    = 1'b1;
    thr     = 6'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || ones !== 6'd4 || above !== 1'b1 || ovf !== 1'b0) begin
        $display("FAIL bp_hold%0d: got valid=%0d ready=%0d ones=%0d above=%0d ovf=%0d expected 1/0/4/1/0",
                 i, valid_o, ready_o, ones, above, ovf); n_fail++;
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || ones !== 6'd4) begin
      $display("FAIL bp_release: got valid=%0d ready=%0d ones=%0d expected 0/1/4", valid_o, ready_o, ones); n_fail++;
    end
    drive_word(8'h03, 1'b1, 6'd3);
    tick();
    tick();
    n_checks++;
    if (valid_o !== 1'b1 || ones !== 6'd2 || above !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL bp_next: got valid=%0d ones=%0d above=%0d ovf=%0d expected 1/2/0/0", valid_o, ones, above, ovf); n_fail++;
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_word(8'hFF, 1'b0, 6'd0);
    tick();
    tick();
    drive_word(8'hFF, 1'b1, 6'd0);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || ones !== 6'd0) begin
      $display("FAIL rst_mid_state: got valid=%0d ready=%0d ones=%0d expected 0/1/0", valid_o, ready_o, ones); n_fail++;
    end
    tick();
    tick();
    n_checks++;
    if (valid_o !== 1'b0) begin $display("FAIL rst_mid_novalid: got %0d expected 0", valid_o); n_fail++; end
    drive_word(8'h80, 1'b1, 6'd1);
    tick();
    tick();
    n_checks++;
    if (valid_o !== 1'b1 || ones !== 6'd1 || above !== 1'b1 || ovf !== 1'b0) begin
      $display("FAIL rst_mid_next: got valid=%0d ones=%0d above=%0d ovf=%0d expected 1/1/1/0", valid_o, ones, above, ovf); n_fail++;
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    feat    = '0;
    last    = 1'b0;
    thr     = '0;
    test_reset();
    test_single();
    test_frame();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
